// File: rtl/butterfly_sdf_8_pkg.sv
// Shared widths, phase encodings and the complex sample type for the SDF butterfly stage.
package butterfly_sdf_8_pkg;

  localparam int unsigned DATA_W  = 24;
  localparam int unsigned TW_FRAC = 8;
  localparam int unsigned DEPTH   = 8;

  // Phase reported by the twiddle source alongside each sample.
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_BFLY = 2'd1,
    ST_TWID = 2'd2,
    ST_ILL  = 2'd3
  } phase_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/butterfly_sdf_8_if.sv
// Sample/twiddle input and result output bundle of the butterfly stage.
interface butterfly_sdf_8_if;
  import butterfly_sdf_8_pkg::*;

  logic                     in_valid;
  logic signed [DATA_W-1:0] din_r;
  logic signed [DATA_W-1:0] din_i;
  logic [1:0]               state_in;
  logic signed [DATA_W-1:0] w_r;
  logic signed [DATA_W-1:0] w_i;
  logic                     out_valid;
  logic signed [DATA_W-1:0] dout_r;
  logic signed [DATA_W-1:0] dout_i;

  modport master (
    output in_valid, din_r, din_i, state_in, w_r, w_i,
    input  out_valid, dout_r, dout_i
  );

  modport slave (
    input  in_valid, din_r, din_i, state_in, w_r, w_i,
    output out_valid, dout_r, dout_i
  );

endinterface

// File: rtl/butterfly_sdf_8_cmul_q8.sv
// Combinational complex multiply by a Q8 twiddle; full-width products, floor shift, low bits kept.
module cmul_q8
  import butterfly_sdf_8_pkg::*;
(
  input  logic signed [DATA_W-1:0] h_r,
  input  logic signed [DATA_W-1:0] h_i,
  input  logic signed [DATA_W-1:0] w_r,
  input  logic signed [DATA_W-1:0] w_i,
  output logic signed [DATA_W-1:0] p_r,
  output logic signed [DATA_W-1:0] p_i
);

  localparam int unsigned PW = 2 * DATA_W;

  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PW:0]   re_full, im_full;

  // Products and sums kept one bit wider than needed so the shift sees exact values.
  always_comb begin
    p_rr    = PW'(h_r) * PW'(w_r);
    p_ii    = PW'(h_i) * PW'(w_i);
    p_ri    = PW'(h_r) * PW'(w_i);
    p_ir    = PW'(h_i) * PW'(w_r);
    re_full = (PW+1)'(p_rr) - (PW+1)'(p_ii);
    im_full = (PW+1)'(p_ri) + (PW+1)'(p_ir);
    p_r     = DATA_W'(re_full >>> TW_FRAC);
    p_i     = DATA_W'(im_full >>> TW_FRAC);
  end

endmodule

// File: rtl/butterfly_sdf_8.sv
// Single-delay-feedback radix-2 stage: 8-deep feedback line, add/sub butterfly, Q8 twiddle multiply.
module butterfly_sdf_8
  import butterfly_sdf_8_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  butterfly_sdf_8_if.slave   bus
);

  cplx_t  dl [DEPTH];
  cplx_t  head, din_g, push, res, prod;
  logic   active;
  logic   adv;
  logic   shift_en;
  logic   out_en;
  phase_e phase;

  assign phase = phase_e'(bus.state_in);
  assign adv   = bus.in_valid | active;
  assign head  = dl[DEPTH-1];

  // Once streaming starts, cycles without in_valid still advance and feed zeros.
  assign din_g.re = bus.in_valid ? bus.din_r : '0;
  assign din_g.im = bus.in_valid ? bus.din_i : '0;

  cmul_q8 u_cmul (
    .h_r (head.re),
    .h_i (head.im),
    .w_r (bus.w_r),
    .w_i (bus.w_i),
    .p_r (prod.re),
    .p_i (prod.im)
  );

  // Latches the first valid sample after reset; stays set until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) active <= 1'b0;
    else if (bus.in_valid) active <= 1'b1;
  end

  // Phase decode: what to push, what to emit, and whether the line moves.
  always_comb begin
    shift_en = 1'b0;
    out_en   = 1'b0;
    push     = din_g;
    res      = '0;
    if (adv) begin
      case (phase)
        ST_FILL: begin
          shift_en = 1'b1;
        end
        ST_BFLY: begin
          shift_en = 1'b1;
          out_en   = 1'b1;
          res.re   = head.re + din_g.re;
          res.im   = head.im + din_g.im;
          push.re  = head.re - din_g.re;
          push.im  = head.im - din_g.im;
        end
        ST_TWID: begin
          shift_en = 1'b1;
          out_en   = 1'b1;
          res      = prod;
        end
        default: ;
      endcase
    end
  end

  // Feedback delay line: entry 0 receives, entry DEPTH-1 is the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) dl[i] <= '0;
    end else if (shift_en) begin
      dl[0] <= push;
      for (int unsigned i = 1; i < DEPTH; i++) dl[i] <= dl[i-1];
    end
  end

  // Registered result; data holds whenever no new result is produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.dout_r    <= '0;
      bus.dout_i    <= '0;
    end else begin
      bus.out_valid <= out_en;
      if (out_en) begin
        bus.dout_r <= res.re;
        bus.dout_i <= res.im;
      end
    end
  end

endmodule

// File: doc/butterfly_sdf_8.md
BUTTERFLY_SDF_8 -- requirements
Module: butterfly_sdf_8

Interface
REQ-001 SHALL: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL: in_valid  input  1  din sample valid this cycle.
REQ-004 SHALL: din_r, din_i  input  24 each  signed two's-complement complex sample.
REQ-005 SHALL: state_in  input  2  stage phase from twiddle source; 0 = fill, 1 = butterfly, 2 = twiddle-multiply, 3 = illegal.
REQ-006 SHALL: w_r, w_i  input  24 each  signed twiddle, Q8 fixed point (256 = 1.0), aligned with state_in in the same cycle.
REQ-007 SHALL: out_valid  output  1  dout valid this cycle.
REQ-008 SHALL: dout_r, dout_i  output  24 each  signed complex result.

Function
REQ-009 SHALL: advance (adv) = in_valid OR active; active is set on the first in_valid after reset and stays set until reset.
REQ-010 SHALL: hold an 8-entry complex delay line (24+24 bits); it shifts one position only in adv cycles with state_in in {0,1,2}.
REQ-011 SHALL: state_in=0 with adv: push din into delay line; out_valid=0 next cycle.
REQ-012 SHALL: state_in=1 with adv: a = delay head, b = din; dout = a+b; push a-b into delay line.
REQ-013 SHALL: state_in=2 with adv: h = delay head; dout = h*W; push din into delay line. In_valid low during flush pushes 0.
REQ-014 SHALL: complex multiply: re = (h_r*w_r - h_i*w_i), im = (h_r*w_i + h_i*w_r), full 48-bit products, arithmetic shift right 8 (floor), keep low 24 bits.
REQ-015 SHALL: add/sub wrap modulo 2^24; no saturation, no overflow flag.
REQ-016 SHALL: outputs are registered; latency din -> dout is exactly 1 cycle in states 1 and 2; out_valid is 1 the cycle after an adv cycle with state_in in {1,2}.
REQ-017 SHALL: when out_valid=0, dout_r/dout_i hold their previous value.
REQ-018 SHALL: state_in=3: no shift, no output, delay line unchanged.
REQ-019 SHALL: non-adv cycles: no shift, out_valid=0, regardless of state_in.
REQ-020 SHALL: phase changes (1->2 and 2->1 wrap) take effect on the exact cycle state_in changes, with no bubble.

Reset
REQ-021 SHALL: rst asserted at any time clears delay line to 0, active to 0, out_valid to 0, dout_r/dout_i to 0, effective immediately.
REQ-022 SHALL: after rst deasserts, the block stays idle until the next in_valid, then follows state_in from that cycle.

Structure
REQ-023 SHALL: a shared package holds DATA_W=24, TW_FRAC=8, DEPTH=8 and the state_in encodings (ST_FILL, ST_BFLY, ST_TWID).
REQ-024 SHALL: the complex multiply is one sub-module, cmul_q8 (combinational, 24x24 complex in, 24-bit complex out per REQ-014).
REQ-025 SHALL: the delay line is a plain shift register (no RAM inference required).

Verification
REQ-026 SHALL: fill + butterfly: 8 samples din=(k+1,0) in state 0, then 8 samples din=(0,0) in state 1 -> dout = (1,0)..(8,0), out_valid high 8 consecutive cycles, 1 cycle latency.
REQ-027 SHALL: twiddle phase after REQ-026, state 2, W=(256,0) at k=0 and (0,-256) at k=4 -> dout (1,0) and (0,-5).
REQ-028 SHALL: rounding: head=(100,0), W=(237,-98) -> dout=(92,-39).
REQ-029 SHALL: wrap: a=(0x7FFFFF,0), b=(1,0) in state 1 -> dout_r=0x800000; pushed diff=0x7FFFFE.
REQ-030 SHALL: flush: in_valid drops after fill+butterfly, state_in continues 2 -> dout streams 8 twiddled samples with out_valid high, zeros pushed.
REQ-031 SHALL: reset mid-run: rst pulsed during state 1 -> same cycle out_valid=0, dout=0; after release, no output until new in_valid plus 8 fill cycles.
